// File: rtl/geofence_pkg.sv
// Shared types, defaults and width helper for the geofence scheduler and its arbiter.
package geofence_pkg;

  localparam int DEF_SET_LEN = 6;
  localparam int DEF_W       = 8;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    WAIT
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping modulo NREQ.
module rr_arbiter
  import geofence_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = idx_w(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [NREQ-1:0]  onehot,
  output logic [IDX_W-1:0] idx
);

  int cand;

  // Scan from the farthest candidate back to ptr so the nearest requester overwrites the others.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (req[IDX_W'(cand)]) begin
        valid = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
    onehot = valid ? (NREQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/geofence_sched.sv
// Shares one geo-fence sorting engine among NREQ requesters: feeds a granted point set,
// returns the engine's ordered results tagged with the requester index, aborts on engine stall.
module geofence_sched
  import geofence_pkg::*;
#(
  parameter int  NREQ    = 2,
  parameter int  SET_LEN = DEF_SET_LEN,
  parameter int  W       = DEF_W,
  parameter int  TIMEOUT = 1023,
  localparam int IDX_W   = idx_w(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   grant,
  input  logic [NREQ-1:0]   pt_valid,
  input  logic [NREQ*W-1:0] pt_x,
  input  logic [NREQ*W-1:0] pt_y,
  output logic              eng_give_valid,
  output logic [W-1:0]      eng_x,
  output logic [W-1:0]      eng_y,
  input  logic              eng_out_valid,
  input  logic [W-1:0]      eng_ans_x,
  input  logic [W-1:0]      eng_ans_y,
  output logic              res_valid,
  output logic [W-1:0]      res_x,
  output logic [W-1:0]      res_y,
  output logic [IDX_W-1:0]  res_id,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(SET_LEN + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]  res_id_q, res_id_d;
  logic [CNT_W-1:0]  pt_cnt_q, pt_cnt_d;
  logic [CNT_W-1:0]  res_cnt_q, res_cnt_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              give_q, give_d;
  logic [W-1:0]      eng_x_q, eng_x_d, eng_y_q, eng_y_d;
  logic              res_valid_q, res_valid_d;
  logic [W-1:0]      res_x_q, res_x_d, res_y_q, res_y_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              arb_valid;
  logic [NREQ-1:0]   arb_onehot;
  logic [IDX_W-1:0]  arb_idx;
  logic              sel_valid;
  logic [W-1:0]      sel_x, sel_y;
  logic [IDX_W-1:0]  next_ptr;
  logic              finish;

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .req    (req),
    .ptr    (ptr_q),
    .valid  (arb_valid),
    .onehot (arb_onehot),
    .idx    (arb_idx)
  );

  // res_id_q doubles as the granted index while a set is in flight.
  assign sel_valid = pt_valid[res_id_q];
  assign sel_x     = pt_x[int'(res_id_q)*W +: W];
  assign sel_y     = pt_y[int'(res_id_q)*W +: W];
  assign next_ptr  = (res_id_q == IDX_W'(NREQ - 1)) ? '0 : res_id_q + IDX_W'(1);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    res_id_d    = res_id_q;
    pt_cnt_d    = pt_cnt_q;
    res_cnt_d   = res_cnt_q;
    timer_d     = timer_q;
    give_d      = 1'b0;
    eng_x_d     = eng_x_q;
    eng_y_d     = eng_y_q;
    res_valid_d = 1'b0;
    res_x_d     = res_x_q;
    res_y_d     = res_y_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    finish      = 1'b0;
    case (state_q)
      IDLE: begin
        err_d = eng_out_valid;
        if (arb_valid) begin
          grant_d   = arb_onehot;
          res_id_d  = arb_idx;
          pt_cnt_d  = '0;
          res_cnt_d = '0;
          state_d   = FEED;
        end
      end
      FEED: begin
        err_d = eng_out_valid;
        if (sel_valid) begin
          give_d  = 1'b1;
          eng_x_d = sel_x;
          eng_y_d = sel_y;
          if (pt_cnt_q == CNT_W'(SET_LEN - 1)) begin
            pt_cnt_d = '0;
            timer_d  = '0;
            state_d  = WAIT;
          end else begin
            pt_cnt_d = pt_cnt_q + CNT_W'(1);
          end
        end
      end
      WAIT: begin
        if (eng_out_valid) begin
          res_valid_d = 1'b1;
          res_x_d     = eng_ans_x;
          res_y_d     = eng_ans_y;
          timer_d     = '0;
          if (res_cnt_q == CNT_W'(SET_LEN - 1)) finish = 1'b1;
          else res_cnt_d = res_cnt_q + CNT_W'(1);
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          err_d  = 1'b1;
          finish = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Completion and timeout abort release the engine identically.
    if (finish) begin
      grant_d   = '0;
      done_d    = 1'b1;
      ptr_d     = next_ptr;
      res_cnt_d = '0;
      timer_d   = '0;
      state_d   = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      res_id_q    <= '0;
      pt_cnt_q    <= '0;
      res_cnt_q   <= '0;
      timer_q     <= '0;
      give_q      <= 1'b0;
      eng_x_q     <= '0;
      eng_y_q     <= '0;
      res_valid_q <= 1'b0;
      res_x_q     <= '0;
      res_y_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      res_id_q    <= res_id_d;
      pt_cnt_q    <= pt_cnt_d;
      res_cnt_q   <= res_cnt_d;
      timer_q     <= timer_d;
      give_q      <= give_d;
      eng_x_q     <= eng_x_d;
      eng_y_q     <= eng_y_d;
      res_valid_q <= res_valid_d;
      res_x_q     <= res_x_d;
      res_y_q     <= res_y_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign grant          = grant_q;
  assign eng_give_valid = give_q;
  assign eng_x          = eng_x_q;
  assign eng_y          = eng_y_q;
  assign res_valid      = res_valid_q;
  assign res_x          = res_x_q;
  assign res_y          = res_y_q;
  assign res_id         = res_id_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_geofence_sched.sv
// Bench for geofence_sched: directed scenarios and randomized sets checked against a
// round-robin pointer model, with the bench itself playing the sorting engine.
module tb_geofence_sched;

  localparam int NREQ    = 2;
  localparam int SET_LEN = 6;
  localparam int W       = 8;
  localparam int TIMEOUT = 16;
  localparam int PW      = NREQ * W;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] pt_valid = '0;
  logic [PW-1:0]   pt_x = '0;
  logic [PW-1:0]   pt_y = '0;
  logic            eng_give_valid;
  logic [W-1:0]    eng_x, eng_y;
  logic            eng_out_valid = 1'b0;
  logic [W-1:0]    eng_ans_x = '0;
  logic [W-1:0]    eng_ans_y = '0;
  logic            res_valid;
  logic [W-1:0]    res_x, res_y;
  logic [0:0]      res_id;
  logic            done, err;

  int checks = 0;
  int failures = 0;
  int ptr_m = 0;
  logic [W-1:0] px[SET_LEN];
  logic [W-1:0] py[SET_LEN];

  geofence_sched #(.NREQ(NREQ), .SET_LEN(SET_LEN), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .grant          (grant),
    .pt_valid       (pt_valid),
    .pt_x           (pt_x),
    .pt_y           (pt_y),
    .eng_give_valid (eng_give_valid),
    .eng_x          (eng_x),
    .eng_y          (eng_y),
    .eng_out_valid  (eng_out_valid),
    .eng_ans_x      (eng_ans_x),
    .eng_ans_y      (eng_ans_y),
    .res_valid      (res_valid),
    .res_x          (res_x),
    .res_y          (res_y),
    .res_id         (res_id),
    .done           (done),
    .err            (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: first requesting index at or after the pointer, modulo NREQ.
  function automatic int pickModel(input logic [NREQ-1:0] r, input int p);
    int j;
    for (int k = 0; k < NREQ; k++) begin
      j = (p + k) % NREQ;
      if (((r >> j) & NREQ'(1)) != '0) return j;
    end
    return -1;
  endfunction

  task automatic fillRandom();
    for (int i = 0; i < SET_LEN; i++) begin
      px[i] = W'($urandom);
      py[i] = W'($urandom);
    end
  endtask

  task automatic applyStimulus(input int gmin, input int gmax, input bit stray, input bit extra,
                               input bit clash, input int n_res, input bit abort_rst,
                               input logic [NREQ-1:0] req_after);
    int r, gap, cnt;
    r = pickModel(req, ptr_m);
    tick();
    checkOutput("grant", 32'(grant), 32'(1) << r);
    checkOutput("res_id_load", 32'(res_id), 32'(r));
    checkOutput("done_once", 32'(done), 0);
    req = req_after;
    for (int i = 0; i < SET_LEN; i++) begin
      pt_x = PW'($urandom);
      pt_y = PW'($urandom);
      pt_x[r*W +: W] = px[i];
      pt_y[r*W +: W] = py[i];
      pt_valid = (stray ? NREQ'($urandom) : '0) | (NREQ'(1) << r);
      eng_out_valid = clash && (i == SET_LEN - 1);
      tick();
      eng_out_valid = 1'b0;
      checkOutput("fwd_valid", 32'(eng_give_valid), 1);
      checkOutput("fwd_x", 32'(eng_x), 32'(px[i]));
      checkOutput("fwd_y", 32'(eng_y), 32'(py[i]));
      checkOutput("feed_err", 32'(err), (clash && i == SET_LEN - 1) ? 1 : 0);
      gap = $urandom_range(gmax, gmin);
      for (int g = 0; g < gap; g++) begin
        pt_valid = stray ? (NREQ'($urandom) & ~(NREQ'(1) << r)) : '0;
        tick();
        checkOutput("gap_valid", 32'(eng_give_valid), 0);
      end
    end
    if (extra) begin
      pt_valid = NREQ'(1) << r;
      tick();
      checkOutput("extra_ignored", 32'(eng_give_valid), 0);
    end
    pt_valid = '0;
    for (int k = 0; k < n_res; k++) begin
      gap = $urandom_range(3, 0);
      for (int g = 0; g < gap; g++) begin
        tick();
        checkOutput("res_idle", 32'(res_valid), 0);
      end
      eng_out_valid = 1'b1;
      eng_ans_x = px[SET_LEN-1-k];
      eng_ans_y = py[SET_LEN-1-k];
      tick();
      eng_out_valid = 1'b0;
      checkOutput("res_valid", 32'(res_valid), 1);
      checkOutput("res_x", 32'(res_x), 32'(px[SET_LEN-1-k]));
      checkOutput("res_y", 32'(res_y), 32'(py[SET_LEN-1-k]));
      checkOutput("res_id", 32'(res_id), 32'(r));
      checkOutput("res_done", 32'(done), (k == SET_LEN - 1) ? 1 : 0);
      checkOutput("res_err", 32'(err), 0);
      if (k == SET_LEN - 1) checkOutput("grant_drop", 32'(grant), 0);
    end
    if (n_res == SET_LEN) begin
      ptr_m = (r + 1) % NREQ;
    end else if (!abort_rst) begin
      cnt = 0;
      do begin
        tick();
        cnt++;
      end while (err !== 1'b1 && cnt < TIMEOUT + 4);
      checkOutput("timeout_cycles", 32'(cnt), TIMEOUT);
      checkOutput("timeout_done", 32'(done), 1);
      checkOutput("timeout_grant", 32'(grant), 0);
      ptr_m = (r + 1) % NREQ;
      eng_out_valid = 1'b1;
      eng_ans_x = 8'h77;
      tick();
      eng_out_valid = 1'b0;
      checkOutput("late_dropped", 32'(res_valid), 0);
    end else begin
      #2 reset = 1'b0;
      #1;
      checkOutput("rst_grant", 32'(grant), 0);
      checkOutput("rst_give", 32'(eng_give_valid), 0);
      checkOutput("rst_eng_x", 32'(eng_x), 0);
      checkOutput("rst_res_valid", 32'(res_valid), 0);
      checkOutput("rst_res_x", 32'(res_x), 0);
      checkOutput("rst_res_id", 32'(res_id), 0);
      checkOutput("rst_done", 32'(done), 0);
      checkOutput("rst_err", 32'(err), 0);
      @(posedge clk);
      #1 reset = 1'b1;
      tick();
      checkOutput("rst_no_done", 32'(done), 0);
      checkOutput("rst_no_err", 32'(err), 0);
      ptr_m = 0;
    end
  endtask

  initial begin
    #500000;
    failures++;
    $display("[TB] FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tick();
    tick();
    checkOutput("reset_grant", 32'(grant), 0);
    checkOutput("reset_give", 32'(eng_give_valid), 0);
    checkOutput("reset_res_valid", 32'(res_valid), 0);
    checkOutput("reset_done", 32'(done), 0);
    checkOutput("reset_err", 32'(err), 0);
    reset = 1'b1;
    tick();

    $display("[TB] single set from requester 0");
    px = '{8'd10, 8'd30, 8'd50, 8'd15, 8'd5, 8'd45};
    py = '{8'd20, 8'd5, 8'd40, 8'd60, 8'd10, 8'd55};
    req = 2'b01;
    applyStimulus(0, 0, 1'b0, 1'b0, 1'b0, SET_LEN, 1'b0, 2'b00);

    $display("[TB] gaps, stray strobes, extra point, point/engine clash");
    fillRandom();
    req = 2'b10;
    applyStimulus(2, 2, 1'b1, 1'b1, 1'b1, SET_LEN, 1'b0, 2'b00);

    $display("[TB] fairness with both requesting");
    req = 2'b11;
    for (int s = 0; s < 4; s++) begin
      fillRandom();
      applyStimulus(0, 1, 1'b0, 1'b0, 1'b0, SET_LEN, 1'b0, (s < 3) ? 2'b11 : 2'b00);
    end

    $display("[TB] engine stall timeout");
    fillRandom();
    req = 2'b01;
    applyStimulus(0, 1, 1'b0, 1'b0, 1'b0, 3, 1'b0, 2'b00);

    $display("[TB] engine strobe while idle");
    eng_out_valid = 1'b1;
    eng_ans_x = 8'h5A;
    tick();
    eng_out_valid = 1'b0;
    checkOutput("proto_err", 32'(err), 1);
    checkOutput("proto_no_res", 32'(res_valid), 0);
    checkOutput("proto_grant", 32'(grant), 0);
    tick();
    checkOutput("proto_err_clear", 32'(err), 0);

    $display("[TB] reset in the middle of a set");
    fillRandom();
    req = 2'b11;
    applyStimulus(0, 1, 1'b0, 1'b0, 1'b0, 2, 1'b1, 2'b00);
    fillRandom();
    req = 2'b10;
    applyStimulus(0, 1, 1'b0, 1'b0, 1'b0, SET_LEN, 1'b0, 2'b00);

    $display("[TB] randomized sets");
    for (int s = 0; s < 8; s++) begin
      if (req == '0) req = NREQ'($urandom_range(3, 1));
      fillRandom();
      applyStimulus(0, 2, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                    1'($urandom_range(1, 0)), SET_LEN, 1'b0, NREQ'($urandom));
    end
    req = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
